// File: rtl/dmem_arb_pkg.sv
// ----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types and constants for the data-memory port-B arbiter.
//   mem_req_t  : one requester's access (byte address, write flag, byte
//                enables, write data)
//   mem_resp_t : one response (read data, range error)
//   req_id_t   : requester identifier (0 = core data bus, 1 = host bus)
//   WORD_SHIFT : byte address -> RAM word index shift
// ----------------------------------------------------------------------------
package dmem_arb_pkg;

    localparam int ADDR_BITS  = 32;
    localparam int DATA_BITS  = 32;
    localparam int STRB_BITS  = DATA_BITS / 8;
    localparam int WORD_SHIFT = 2;

    typedef logic req_id_t;

    typedef struct packed {
        logic [ADDR_BITS-1:0] addr;
        logic                 wen;
        logic [STRB_BITS-1:0] strb;
        logic [DATA_BITS-1:0] wdata;
    } mem_req_t;

    typedef struct packed {
        logic [DATA_BITS-1:0] rdata;
        logic                 err;
    } mem_resp_t;

    // Byte address to word index; the low WORD_SHIFT bits are dropped.
    function automatic logic [ADDR_BITS-1:0] word_index(input logic [ADDR_BITS-1:0] byte_addr);
        return byte_addr >> WORD_SHIFT;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter. The grant is combinational. The last winner
// is remembered, and the other requester wins when both are asking.
//   clk, rst_n : clock, asynchronous active-low reset (last winner -> 1)
//   enable     : 0 grants nothing and leaves the last winner untouched
//   valid[1:0] : request present per requester
//   grant[1:0] : one-hot grant; a grant is always an accept (no back-pressure)
//   grant_id   : index of the granted requester (meaningful when |grant)
// ----------------------------------------------------------------------------
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [1:0] valid,
    output logic [1:0] grant,
    output req_id_t    grant_id
);

    req_id_t last_grant_reg;

    always_comb begin
        grant    = '0;
        // Contention goes to the side that did not win last. A lone request wins outright.
        grant_id = (valid == 2'b11) ? ~last_grant_reg : valid[1];
        if (enable && (|valid)) begin
            grant[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= 1'b1;   // so r0 wins the first contention
        end else if (|grant) begin
            last_grant_reg <= grant_id;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_port_arbiter
// Shares RAM port B between the core data bus (r0) and the host loader/debug
// bus (r1). Each accepted request drives the RAM in the same cycle. It gets
// exactly one response one cycle later. Out-of-range word indices are
// accepted, but they never touch the RAM, and they answer with err=1.
//   clk, rst_n       : clock, asynchronous active-low reset
//   hold             : 1 = accept nothing new (pending response still issues)
//   rN_req_*         : request channel N (valid/ready handshake, byte address)
//   rN_resp_*        : one-cycle response pulse with rdata / err
//   addrb, renb, wenb, webb, datab : RAM port B drive (addrb is a word index)
//   qb               : RAM port B read data, valid the cycle after renb
// ----------------------------------------------------------------------------
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int p_ADDR_BITS = ADDR_BITS,
    parameter int p_DATA_BITS = DATA_BITS,
    parameter int p_STRB_BITS = p_DATA_BITS / 8,
    parameter int p_MEM_WORDS = 65536
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   hold,

    input  logic                   r0_req_valid,
    output logic                   r0_req_ready,
    input  logic [p_ADDR_BITS-1:0] r0_req_addr,
    input  logic                   r0_req_wen,
    input  logic [p_STRB_BITS-1:0] r0_req_strb,
    input  logic [p_DATA_BITS-1:0] r0_req_wdata,
    output logic                   r0_resp_valid,
    output logic [p_DATA_BITS-1:0] r0_resp_rdata,
    output logic                   r0_resp_err,

    input  logic                   r1_req_valid,
    output logic                   r1_req_ready,
    input  logic [p_ADDR_BITS-1:0] r1_req_addr,
    input  logic                   r1_req_wen,
    input  logic [p_STRB_BITS-1:0] r1_req_strb,
    input  logic [p_DATA_BITS-1:0] r1_req_wdata,
    output logic                   r1_resp_valid,
    output logic [p_DATA_BITS-1:0] r1_resp_rdata,
    output logic                   r1_resp_err,

    output logic [p_ADDR_BITS-1:0] addrb,
    output logic                   renb,
    output logic                   wenb,
    output logic [p_STRB_BITS-1:0] webb,
    output logic [p_DATA_BITS-1:0] datab,
    input  logic [p_DATA_BITS-1:0] qb
);

    mem_req_t                req [2];
    mem_req_t                sel;
    logic [1:0]              grant;
    req_id_t                 grant_id;
    logic                    accept;
    logic [p_ADDR_BITS-1:0]  word;
    logic                    in_range;

    logic                    resp_valid_reg;
    req_id_t                 resp_id_reg;
    logic                    resp_rd_reg;
    logic                    resp_err_reg;
    mem_resp_t               resp;
    logic [1:0]              resp_hit;
    mem_resp_t               side_resp [2];

    assign req[0] = {r0_req_addr, r0_req_wen, r0_req_strb, r0_req_wdata};
    assign req[1] = {r1_req_addr, r1_req_wen, r1_req_strb, r1_req_wdata};

    // Gating by rst_n keeps the combinational RAM strobes low during reset,
    // even when a requester holds valid high.
    rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (~hold & rst_n),
        .valid    ({r1_req_valid, r0_req_valid}),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign r0_req_ready = grant[0];
    assign r1_req_ready = grant[1];
    assign accept       = |grant;

    assign sel      = req[grant_id];
    assign word     = word_index(sel.addr);
    assign in_range = word < p_ADDR_BITS'(p_MEM_WORDS);

    assign addrb = word;
    assign renb  = accept & in_range & ~sel.wen;
    assign wenb  = accept & in_range &  sel.wen;
    assign webb  = wenb ? sel.strb : '0;
    assign datab = sel.wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_reg <= 1'b0;
            resp_id_reg    <= 1'b0;
            resp_rd_reg    <= 1'b0;
            resp_err_reg   <= 1'b0;
        end else begin
            resp_valid_reg <= accept;
            resp_id_reg    <= grant_id;
            resp_rd_reg    <= ~sel.wen;
            resp_err_reg   <= ~in_range;
        end
    end

    // qb passes straight through. The RAM output register already supplies the
    // one-cycle read latency.
    assign resp.rdata = (resp_valid_reg & resp_rd_reg & ~resp_err_reg) ? qb : '0;
    assign resp.err   = resp_valid_reg & resp_err_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_resp
            assign resp_hit[gi]  = resp_valid_reg & (resp_id_reg == req_id_t'(gi));
            assign side_resp[gi] = resp_hit[gi] ? resp : '0;
        end
    endgenerate

    assign r0_resp_valid = resp_hit[0];
    assign r0_resp_rdata = side_resp[0].rdata;
    assign r0_resp_err   = side_resp[0].err;
    assign r1_resp_valid = resp_hit[1];
    assign r1_resp_rdata = side_resp[1].rdata;
    assign r1_resp_err   = side_resp[1].err;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dmem_port_arbiter
// The stimulus process drives one cycle at a time. It predicts the grant from
// the round-robin rule and checks the handshake and the RAM strobes. For each
// accept it queues the expected response, which it takes from a shadow memory.
// A separate monitor pops the queue and compares on every response pulse.
// ----------------------------------------------------------------------------
module tb_dmem_port_arbiter;

    typedef struct {
        bit        v;
        bit [31:0] a;
        bit        w;
        bit [3:0]  s;
        bit [31:0] d;
    } tb_req_t;

    typedef struct {
        bit [31:0] rdata;
        bit        err;
        int        cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hold = 1'b0;
    logic        r0_req_valid = 1'b0, r1_req_valid = 1'b0;
    logic        r0_req_ready, r1_req_ready;
    logic [31:0] r0_req_addr = '0, r1_req_addr = '0;
    logic        r0_req_wen = 1'b0, r1_req_wen = 1'b0;
    logic [3:0]  r0_req_strb = '0, r1_req_strb = '0;
    logic [31:0] r0_req_wdata = '0, r1_req_wdata = '0;
    logic        r0_resp_valid, r1_resp_valid;
    logic [31:0] r0_resp_rdata, r1_resp_rdata;
    logic        r0_resp_err, r1_resp_err;
    logic [31:0] addrb;
    logic        renb, wenb;
    logic [3:0]  webb;
    logic [31:0] datab;
    logic [31:0] qb = '0;

    bit [31:0]   ram     [65536];   // the RAM attached to port B
    bit [31:0]   ref_mem [65536];   // what the memory should hold
    exp_t        rq0[$], rq1[$];
    int          last = 1;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter dut (
        .clk(clk), .rst_n(rst_n), .hold(hold),
        .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready), .r0_req_addr(r0_req_addr),
        .r0_req_wen(r0_req_wen), .r0_req_strb(r0_req_strb), .r0_req_wdata(r0_req_wdata),
        .r0_resp_valid(r0_resp_valid), .r0_resp_rdata(r0_resp_rdata), .r0_resp_err(r0_resp_err),
        .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready), .r1_req_addr(r1_req_addr),
        .r1_req_wen(r1_req_wen), .r1_req_strb(r1_req_strb), .r1_req_wdata(r1_req_wdata),
        .r1_resp_valid(r1_resp_valid), .r1_resp_rdata(r1_resp_rdata), .r1_resp_err(r1_resp_err),
        .addrb(addrb), .renb(renb), .wenb(wenb), .webb(webb), .datab(datab), .qb(qb)
    );

    // Synchronous RAM with registered read.
    always @(posedge clk) begin
        if (wenb) begin
            for (int b = 0; b < 4; b++)
                if (webb[b]) ram[addrb[15:0]][b*8 +: 8] <= datab[b*8 +: 8];
        end
        if (renb) qb <= ram[addrb[15:0]];
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic tb_req_t mk(input bit v, input bit [31:0] a, input bit w,
                                   input bit [3:0] s, input bit [31:0] d);
        tb_req_t r;
        r.v = v; r.a = a; r.w = w; r.s = s; r.d = d;
        return r;
    endfunction

    function automatic tb_req_t rnd_req();
        bit [31:0] wd;
        wd = ($urandom_range(0, 9) == 0) ? 32'(65536 + $urandom_range(0, 100)) : 32'($urandom_range(0, 15));
        return mk($urandom_range(0, 3) != 0, (wd << 2) | 32'($urandom_range(0, 3)),
                  1'($urandom), 4'($urandom), $urandom);
    endfunction

    // One clock cycle: drive, predict, check handshake/RAM strobes, queue response.
    task automatic step(input tb_req_t q0, input tb_req_t q1, input bit h, input bit rn);
        int        g;
        bit        inr;
        tb_req_t   s;
        bit [31:0] wd;
        exp_t      e;
        @(posedge clk);
        #1;
        r0_req_valid = q0.v; r0_req_addr = q0.a; r0_req_wen = q0.w; r0_req_strb = q0.s; r0_req_wdata = q0.d;
        r1_req_valid = q1.v; r1_req_addr = q1.a; r1_req_wen = q1.w; r1_req_strb = q1.s; r1_req_wdata = q1.d;
        hold = h;
        rst_n = rn;
        if (!rn) begin
            rq0.delete(); rq1.delete();
            last = 1;
        end
        #3;
        g = -1;
        if (rn && !h) begin
            if (q0.v && q1.v) g = (last == 0) ? 1 : 0;
            else if (q0.v)    g = 0;
            else if (q1.v)    g = 1;
        end
        chk("r0_req_ready", r0_req_ready, 32'(g == 0));
        chk("r1_req_ready", r1_req_ready, 32'(g == 1));
        if (g >= 0) begin
            s   = (g == 0) ? q0 : q1;
            wd  = s.a >> 2;
            inr = wd < 65536;
            chk("renb", renb, 32'(inr && !s.w));
            chk("wenb", wenb, 32'(inr && s.w));
            if (inr) begin
                chk("addrb", addrb, wd);
                if (s.w) begin
                    chk("webb", webb, 32'(s.s));
                    chk("datab", datab, s.d);
                end
            end
            e.err   = !inr;
            e.rdata = (inr && !s.w) ? ref_mem[wd[15:0]] : 32'h0;
            e.cyc   = cyc + 1;
            if (inr && s.w)
                for (int b = 0; b < 4; b++)
                    if (s.s[b]) ref_mem[wd[15:0]][b*8 +: 8] = s.d[b*8 +: 8];
            if (g == 0) rq0.push_back(e); else rq1.push_back(e);
            last = g;
        end else begin
            chk("renb_idle", renb, 0);
            chk("wenb_idle", wenb, 0);
            if (!rn) begin
                chk("webb_rst", webb, 0);
                chk("r0_resp_valid_rst", r0_resp_valid, 0);
                chk("r1_resp_valid_rst", r1_resp_valid, 0);
                chk("r0_resp_rdata_rst", r0_resp_rdata, 0);
                chk("r1_resp_rdata_rst", r1_resp_rdata, 0);
                chk("r0_resp_err_rst", r0_resp_err, 0);
                chk("r1_resp_err_rst", r1_resp_err, 0);
            end
        end
    endtask

    task automatic mon(input int n, input logic v, input logic [31:0] rd, input logic er);
        exp_t e;
        bit   have;
        have = (n == 0) ? (rq0.size() > 0) : (rq1.size() > 0);
        if (v) begin
            if (!have) begin
                n_checks++; n_fail++;
                $display("FAIL r%0d_resp_unexpected: got resp_valid=1 required 0 (cycle %0d)", n, cyc);
            end else begin
                e = (n == 0) ? rq0.pop_front() : rq1.pop_front();
                chk($sformatf("r%0d_resp_rdata", n), rd, e.rdata);
                chk($sformatf("r%0d_resp_err", n), 32'(er), 32'(e.err));
                chk($sformatf("r%0d_resp_cycle", n), cyc, e.cyc);
            end
        end else if (have) begin
            e = (n == 0) ? rq0[0] : rq1[0];
            if (e.cyc <= cyc) begin
                n_checks++; n_fail++;
                $display("FAIL r%0d_resp_missing: got resp_valid=0 required 1 (cycle %0d)", n, cyc);
                if (n == 0) void'(rq0.pop_front()); else void'(rq1.pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, r0_resp_valid, r0_resp_rdata, r0_resp_err);
        mon(1, r1_resp_valid, r1_resp_rdata, r1_resp_err);
    end

    initial begin
        tb_req_t idle;
        idle = mk(0, 0, 0, 0, 0);

        // reset state
        step(idle, idle, 0, 0);
        step(idle, idle, 0, 0);
        step(idle, idle, 0, 1);

        // write 0x10 then read it back
        step(mk(1, 32'h10, 1, 4'hF, 32'hDEADBEEF), idle, 0, 1);
        step(mk(1, 32'h10, 0, 4'h0, 32'h0), idle, 0, 1);
        step(idle, idle, 0, 1);

        // partial byte write from r1, then a write with no byte enables
        step(idle, mk(1, 32'h20, 1, 4'hF, 32'h11223344), 0, 1);
        step(idle, mk(1, 32'h20, 1, 4'h2, 32'h0000AB00), 0, 1);
        step(idle, mk(1, 32'h20, 0, 4'h0, 32'h0), 0, 1);
        step(mk(1, 32'h22, 1, 4'h0, 32'hFFFFFFFF), idle, 0, 1);
        step(mk(1, 32'h20, 0, 4'h0, 32'h0), idle, 0, 1);

        // sustained contention: alternating grants
        for (int i = 0; i < 6; i++)
            step(mk(1, 32'h10, 0, 0, 0), mk(1, 32'h20, 0, 0, 0), 0, 1);

        // hold with both requesting, then release
        for (int i = 0; i < 3; i++)
            step(mk(1, 32'h10, 0, 0, 0), mk(1, 32'h20, 0, 0, 0), 1, 1);
        step(mk(1, 32'h10, 0, 0, 0), mk(1, 32'h20, 0, 0, 0), 0, 1);
        step(idle, idle, 0, 1);

        // first out-of-range word
        step(mk(1, 32'h0004_0000, 0, 0, 0), idle, 0, 1);
        step(mk(1, 32'h0004_0000, 1, 4'hF, 32'h12345678), idle, 0, 1);
        step(idle, idle, 0, 1);

        // reset in the cycle after a read accept drops the response
        step(idle, mk(1, 32'h10, 0, 0, 0), 0, 1);
        step(idle, idle, 0, 0);
        step(idle, idle, 0, 1);
        step(mk(1, 32'h10, 0, 0, 0), mk(1, 32'h20, 0, 0, 0), 0, 1);
        step(mk(1, 32'h10, 0, 0, 0), mk(1, 32'h20, 0, 0, 0), 0, 1);

        // randomized traffic with occasional hold and one reset
        for (int i = 0; i < 400; i++)
            step(rnd_req(), rnd_req(), $urandom_range(0, 7) == 0, i != 200);

        // drain
        step(idle, idle, 0, 1);
        step(idle, idle, 0, 1);
        step(idle, idle, 0, 1);
        @(posedge clk);
        #2;
        chk("r0_queue_empty", rq0.size(), 0);
        chk("r1_queue_empty", rq1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
